speed_error: RTL and testbench
==============================

Name: speed_error

Overview:
- Upstream neighbour of the D-error stage in the BLDC speed loop.
- Decodes the three hall-sensor lines and counts commutation edges over a fixed gate window to measure rotor speed.
- Produces the 9-bit signed speed error Err = setpoint − speed on clk_32, which feeds the derivative-error and PID stages.
- Err updates once per gate window and is flagged by a one-cycle err_valid strobe.

Parameters:
- GATE_CYCLES, 32000, gate window length in clk_32 cycles; legal range 2..65535.
- DEB_CYCLES, 4, consecutive identical synchronized samples required before a hall code is accepted; legal range 1..15.

Ports:
- clk_32  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- hall  in  3  raw asynchronous hall sensor lines {C,B,A}.
- setpoint  in  8  requested speed, in edges per window (unsigned).
- Err  out  9  signed two's-complement speed error.
- err_valid  out  1  one-cycle pulse; Err/speed updated this cycle.
- speed  out  8  measured edges per window, saturated.
- hall_fault  out  1  sticky illegal-hall-code flag.

Behaviour:
- Reset: Err=0, err_valid=0, speed=0, hall_fault=0. Synchronizer, debounce state, hall_stable=3'b000, edge_cnt=0 and gate_cnt=0 are all cleared. rst asserted mid-window discards the partial window.
- hall passes through a 2-flop synchronizer.
- Debounce: hall_stable loads the synchronized value once that value has differed from hall_stable for DEB_CYCLES consecutive cycles. Any mismatch in the run restarts the count.
- Edge event: one cycle in which hall_stable changes, where both the old and the new code are valid (not 000, not 111).
  - Entry into or exit from an invalid code is never counted.
  - The reset value 000 is therefore never counted, and the first valid code after reset is not an edge.
- Fault: hall_fault is set when hall_stable loads 000 or 111. It stays set until rst. Loading the reset value is not a fault.
- Gate counter counts 0..GATE_CYCLES-1 and wraps.
- edge_cnt is 9 bits and saturates at 511.
- At the clock edge where gate_cnt==GATE_CYCLES-1 (terminal):
  - n = edge_cnt + (edge event this cycle ? 1 : 0), so an edge coinciding with terminal belongs to the closing window.
  - speed ← min(n, 255).
  - Err ← {1'b0,setpoint} − {1'b0,speed_new}. Range is −255..+255, so no overflow is possible.
  - setpoint is sampled at this same edge.
  - err_valid ← 1 for exactly one cycle.
  - edge_cnt ← 0.
- Latency: Err, speed and err_valid are valid in the cycle following the terminal edge. Err and speed hold between windows.
- The first err_valid after reset occurs GATE_CYCLES cycles after the rst deassertion edge.

Optional Feature:
- Macro SPEED_AVG_EN.
- Defined: a registered prev_speed (reset 0) is kept. Each window, speed ← (min(n,255) + prev_speed + 1) >> 1, computed with a 9-bit sum, and prev_speed ← min(n,255). Err uses the averaged speed.
- Undefined: speed is the raw saturated count as above, and there is no prev_speed register.

Decomposition:
- Package bldc_pkg holds:
  - ERR_W=9, SPEED_W=8, HALL_W=3;
  - HALL_INVALID_LO=3'b000 and HALL_INVALID_HI=3'b111;
  - the six valid commutation codes as named constants.
- One sub-module, hall_debounce: synchronizer plus debounce, with outputs hall_stable and a changed pulse.
- Gate counter, edge counting and error arithmetic stay in speed_error.

Test Plan (bench overrides GATE_CYCLES=100, DEB_CYCLES=4; clk_32 period 20 ns):
- Reset: rst high 3 cycles with hall toggling → Err=0, speed=0, err_valid=0, hall_fault=0 throughout.
- Setpoint=45, hall held at 101 → err_valid pulses 100 cycles after the rst release edge and every 100 cycles after; Err=9'h02D, speed=0.
- hall rotating 101→100→110→010→011→001 one step per 10 cycles, setpoint=4 → from the second window on, speed=10 and Err=−6 (9'h1FA).
- Saturation with GATE_CYCLES=2000, step every 6 cycles, setpoint=0 → speed=255, Err=−255 (9'h101). With SPEED_AVG_EN, the first window gives speed=128 (0 + 255 + 1 >> 1) and the second gives 255.
- Glitch and fault:
  - a 2-cycle pulse to another code → no edge counted and speed unchanged;
  - hall=111 held 10 cycles → hall_fault=1, which stays 1 after a valid code returns, until rst.
- Mid-window reset: rst for 1 cycle at gate_cnt=50 with 3 edges already counted → next err_valid is exactly 100 cycles after release, and speed counts only post-reset edges.

Source files
------------

// File: rtl/bldc_pkg.sv
// Shared widths, hall code constants and helpers for the BLDC speed loop.
package bldc_pkg;

  localparam int ERR_W   = 9;
  localparam int SPEED_W = 8;
  localparam int HALL_W  = 3;

  typedef logic [HALL_W-1:0] hall_t;

  localparam hall_t HALL_INVALID_LO = 3'b000;
  localparam hall_t HALL_INVALID_HI = 3'b111;

  // Commutation sequence in forward rotation order.
  localparam hall_t HALL_S1 = 3'b101;
  localparam hall_t HALL_S2 = 3'b100;
  localparam hall_t HALL_S3 = 3'b110;
  localparam hall_t HALL_S4 = 3'b010;
  localparam hall_t HALL_S5 = 3'b011;
  localparam hall_t HALL_S6 = 3'b001;

  function automatic logic hall_valid(input hall_t code);
    return (code != HALL_INVALID_LO) && (code != HALL_INVALID_HI);
  endfunction

endpackage

// File: rtl/hall_debounce.sv
// Two-flop synchronizer plus run-length debounce of the hall code.
// o_changed pulses in the first cycle o_stable shows a new code; o_prev holds the code it replaced.
module hall_debounce
  import bldc_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk_32,
  input  logic              rst,
  input  logic [HALL_W-1:0] i_hall,
  output logic [HALL_W-1:0] o_stable,
  output logic [HALL_W-1:0] o_prev,
  output logic              o_changed
);

  localparam logic [4:0] DEB_L = 5'(DEB_CYCLES);

  logic [HALL_W-1:0] r_sync1;
  logic [HALL_W-1:0] r_sync2;
  logic [HALL_W-1:0] r_stable;
  logic [HALL_W-1:0] r_prev;
  logic [HALL_W-1:0] r_cand;
  logic [3:0]        r_run;
  logic              r_changed;
  logic [4:0]        w_run;

  // A different candidate value restarts the run at one.
  always_comb begin
    w_run = 5'd1;
    if ((r_sync2 == r_cand) && (r_run != 4'd0)) w_run = {1'b0, r_run} + 5'd1;
  end

  always_ff @(posedge clk_32) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_stable  <= '0;
      r_prev    <= '0;
      r_cand    <= '0;
      r_run     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_sync1   <= i_hall;
      r_sync2   <= r_sync1;
      r_changed <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_run <= '0;
      end else if (w_run >= DEB_L) begin
        r_prev    <= r_stable;
        r_stable  <= r_sync2;
        r_changed <= 1'b1;
        r_run     <= '0;
      end else begin
        r_cand <= r_sync2;
        r_run  <= w_run[3:0];
      end
    end
  end

  assign o_stable  = r_stable;
  assign o_prev    = r_prev;
  assign o_changed = r_changed;

endmodule

// File: rtl/speed_error.sv
// Hall-edge speed measurement over a gate window and signed error Err = setpoint - speed.
// Define SPEED_AVG_EN to average each window's count with the previous window's count.
module speed_error
  import bldc_pkg::*;
#(
  parameter int GATE_CYCLES = 32000,
  parameter int DEB_CYCLES  = 4
) (
  input  logic               clk_32,
  input  logic               rst,
  input  logic [HALL_W-1:0]  hall,
  input  logic [SPEED_W-1:0] setpoint,
  output logic [ERR_W-1:0]   Err,
  output logic               err_valid,
  output logic [SPEED_W-1:0] speed,
  output logic               hall_fault
);

  localparam logic [15:0] GATE_LAST = 16'(GATE_CYCLES - 1);

  logic [HALL_W-1:0]  w_stable;
  logic [HALL_W-1:0]  w_prev;
  logic               w_changed;
  logic               w_edge;
  logic               w_terminal;
  logic [9:0]         w_n;
  logic [SPEED_W-1:0] w_sat;
  logic [SPEED_W-1:0] w_speed_new;

  logic [15:0]        r_gate_cnt;
  logic [8:0]         r_edge_cnt;
  logic [ERR_W-1:0]   r_err;
  logic               r_err_valid;
  logic [SPEED_W-1:0] r_speed;
  logic               r_fault;

  hall_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk_32   (clk_32),
    .rst      (rst),
    .i_hall   (hall),
    .o_stable (w_stable),
    .o_prev   (w_prev),
    .o_changed(w_changed)
  );

  // Transitions into or out of 000/111 are not commutation edges.
  assign w_edge     = w_changed && hall_valid(w_prev) && hall_valid(w_stable);
  assign w_terminal = (r_gate_cnt == GATE_LAST);
  assign w_n        = {1'b0, r_edge_cnt} + {9'd0, w_edge};
  assign w_sat      = (w_n > 10'd255) ? 8'hFF : w_n[7:0];

`ifdef SPEED_AVG_EN
  logic [SPEED_W-1:0] r_prev_speed;
  logic [8:0]         w_sum;

  assign w_sum       = {1'b0, w_sat} + {1'b0, r_prev_speed} + 9'd1;
  assign w_speed_new = 8'(w_sum >> 1);

  always_ff @(posedge clk_32) begin
    if (rst) r_prev_speed <= '0;
    else if (w_terminal) r_prev_speed <= w_sat;
  end
`else
  assign w_speed_new = w_sat;
`endif

  always_ff @(posedge clk_32) begin
    if (rst) begin
      r_gate_cnt  <= '0;
      r_edge_cnt  <= '0;
      r_err       <= '0;
      r_err_valid <= 1'b0;
      r_speed     <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_err_valid <= 1'b0;
      if (w_changed && !hall_valid(w_stable)) r_fault <= 1'b1;
      if (w_terminal) begin
        r_gate_cnt  <= '0;
        r_edge_cnt  <= '0;
        r_speed     <= w_speed_new;
        r_err       <= {1'b0, setpoint} - {1'b0, w_speed_new};
        r_err_valid <= 1'b1;
      end else begin
        r_gate_cnt <= r_gate_cnt + 16'd1;
        if (w_edge && (r_edge_cnt != 9'h1FF)) r_edge_cnt <= r_edge_cnt + 9'd1;
      end
    end
  end

  assign Err        = r_err;
  assign err_valid  = r_err_valid;
  assign speed      = r_speed;
  assign hall_fault = r_fault;

endmodule

// File: tb/tb_speed_error.sv
// Bench for speed_error: hall schedules are replayed into two instances (short and long gate)
// and every err_valid pulse is compared with a window-count model of the schedule.
module tb_speed_error;
  import bldc_pkg::*;

  localparam int G_A = 100;
  localparam int G_B = 2000;
  localparam int DEB = 4;

  logic       clk_32 = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] hall = 3'b000;
  logic [7:0] setpoint = 8'd0;

  logic [8:0] err_a, err_b;
  logic       ev_a, ev_b, flt_a, flt_b;
  logic [7:0] spd_a, spd_b;

  speed_error #(.GATE_CYCLES(G_A), .DEB_CYCLES(DEB)) dut_a (
    .clk_32(clk_32), .rst(rst), .hall(hall), .setpoint(setpoint),
    .Err(err_a), .err_valid(ev_a), .speed(spd_a), .hall_fault(flt_a));

  speed_error #(.GATE_CYCLES(G_B), .DEB_CYCLES(DEB)) dut_b (
    .clk_32(clk_32), .rst(rst), .hall(hall), .setpoint(setpoint),
    .Err(err_b), .err_valid(ev_b), .speed(spd_b), .hall_fault(flt_b));

  always #10 clk_32 = ~clk_32;

  // Edges since the last edge that sampled rst high.
  int cyc = 0;
  always @(posedge clk_32) cyc <= rst ? 0 : cyc + 1;

  int checks = 0;
  int errors = 0;

  int rot[6];
  int seg_code[$];
  int seg_len[$];
  int play_start;
  int ob_cyc_a[$], ob_spd_a[$], ob_err_a[$];
  int ob_cyc_b[$], ob_spd_b[$], ob_err_b[$];
  int exp_spd[$];
  logic exp_fault;

  task automatic add_seg(input int code, input int len);
    seg_code.push_back(code);
    seg_len.push_back(len);
  endtask

  // Caller is at a negedge; rst is high for n edges and released at a negedge.
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk_32);
    rst = 1'b0;
    ob_cyc_a = {}; ob_spd_a = {}; ob_err_a = {};
    ob_cyc_b = {}; ob_spd_b = {}; ob_err_b = {};
  endtask

  task automatic play();
    play_start = cyc + 1;
    for (int i = 0; i < seg_code.size(); i++) begin
      for (int j = 0; j < seg_len[i]; j++) begin
        hall = 3'(seg_code[i]);
        @(negedge clk_32);
        if (ev_a) begin
          ob_cyc_a.push_back(cyc); ob_spd_a.push_back(int'(spd_a)); ob_err_a.push_back(int'(err_a));
        end
        if (ev_b) begin
          ob_cyc_b.push_back(cyc); ob_spd_b.push_back(int'(spd_b)); ob_err_b.push_back(int'(err_b));
        end
      end
    end
  endtask

  // A code held DEB or more samples becomes the accepted code; the edge is
  // counted DEB+2 edges after it is first sampled (two sync stages plus the run).
  function automatic void model(input int g, input int nwin);
    int cnts[$];
    int st, t, te, w, s, prev;
    cnts = {};
    for (int k = 0; k < nwin; k++) cnts.push_back(0);
    st = 0;
    t = play_start;
    exp_fault = 1'b0;
    for (int i = 0; i < seg_code.size(); i++) begin
      if (seg_len[i] >= DEB && seg_code[i] != st) begin
        te = t + DEB + 2;
        if (hall_valid(3'(st)) && hall_valid(3'(seg_code[i]))) begin
          w = (te - 1) / g;
          if (w < nwin) cnts[w] = cnts[w] + 1;
        end
        if (!hall_valid(3'(seg_code[i]))) exp_fault = 1'b1;
        st = seg_code[i];
      end
      t = t + seg_len[i];
    end
    exp_spd = {};
    prev = 0;
    for (int k = 0; k < nwin; k++) begin
      s = (cnts[k] > 255) ? 255 : cnts[k];
`ifdef SPEED_AVG_EN
      exp_spd.push_back((s + prev + 1) / 2);
`else
      exp_spd.push_back(s);
`endif
      prev = s;
    end
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      hall = 3'($urandom_range(0, 7));
      @(negedge clk_32);
      checks++; if (err_a !== 9'd0) begin errors++; $display("FAIL reset_err got %h want 000", err_a); end
      checks++; if (spd_a !== 8'd0) begin errors++; $display("FAIL reset_speed got %h want 00", spd_a); end
      checks++; if (ev_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ev_a); end
      checks++; if (flt_a !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", flt_a); end
      checks++; if ({err_b, spd_b, ev_b, flt_b} !== 19'd0) begin
        errors++; $display("FAIL reset_b got %h %h %b %b want all zero", err_b, spd_b, ev_b, flt_b);
      end
    end
  endtask

  task automatic test_idle();
    int sp, nw;
    sp = 45; setpoint = 8'(sp);
    seg_code = {}; seg_len = {};
    add_seg(HALL_S1, 350);
    hall = HALL_S1;
    do_reset(3);
    play();
    nw = 350 / G_A;
    model(G_A, nw);
    checks++; if (ob_cyc_a.size() !== nw) begin errors++; $display("FAIL idle_count got %0d want %0d", ob_cyc_a.size(), nw); end
    for (int i = 0; i < ob_cyc_a.size() && i < nw; i++) begin
      checks++; if (ob_cyc_a[i] !== G_A * (i + 1)) begin errors++; $display("FAIL idle_time[%0d] got %0d want %0d", i, ob_cyc_a[i], G_A * (i + 1)); end
      checks++; if (ob_spd_a[i] !== exp_spd[i]) begin errors++; $display("FAIL idle_speed[%0d] got %0d want %0d", i, ob_spd_a[i], exp_spd[i]); end
      checks++; if (ob_err_a[i] !== 'h02D) begin errors++; $display("FAIL idle_err[%0d] got %h want 02d", i, ob_err_a[i]); end
    end
  endtask

  task automatic test_rotate();
    int sp, nw;
    sp = 4; setpoint = 8'(sp);
    seg_code = {}; seg_len = {};
    for (int i = 0; i < 31; i++) add_seg(rot[i % 6], 10);
    hall = 3'(rot[0]);
    do_reset(2);
    play();
    nw = 310 / G_A;
    model(G_A, nw);
    checks++; if (ob_cyc_a.size() !== nw) begin errors++; $display("FAIL rot_count got %0d want %0d", ob_cyc_a.size(), nw); end
    for (int i = 0; i < ob_cyc_a.size() && i < nw; i++) begin
      checks++; if (ob_cyc_a[i] !== G_A * (i + 1)) begin errors++; $display("FAIL rot_time[%0d] got %0d want %0d", i, ob_cyc_a[i], G_A * (i + 1)); end
      checks++; if (ob_spd_a[i] !== exp_spd[i]) begin errors++; $display("FAIL rot_speed[%0d] got %0d want %0d", i, ob_spd_a[i], exp_spd[i]); end
      checks++; if (ob_err_a[i] !== ((sp - exp_spd[i]) & 511)) begin errors++; $display("FAIL rot_err[%0d] got %h want %h", i, ob_err_a[i], (sp - exp_spd[i]) & 511); end
    end
    if (ob_cyc_a.size() > 1) begin
      checks++; if (ob_spd_a[1] !== 10) begin errors++; $display("FAIL rot_speed_w1 got %0d want 10", ob_spd_a[1]); end
      checks++; if (ob_err_a[1] !== 'h1FA) begin errors++; $display("FAIL rot_err_w1 got %h want 1fa", ob_err_a[1]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int sp, total, nxt, gl, len, nw;
      sp = $urandom_range(0, 255); setpoint = 8'(sp);
      seg_code = {}; seg_len = {}; total = 0;
      while (total < 600) begin
        if ($urandom_range(0, 9) == 0) nxt = ($urandom_range(0, 1) == 1) ? 7 : 0;
        else nxt = rot[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) == 0) begin
          gl = rot[$urandom_range(0, 5)];
          if (gl == nxt) gl = (gl == rot[0]) ? rot[1] : rot[0];
          len = $urandom_range(1, DEB - 1);
          add_seg(gl, len); total += len;
        end
        len = $urandom_range(DEB, 14);
        add_seg(nxt, len); total += len;
      end
      hall = 3'(seg_code[0]);
      do_reset(2);
      play();
      nw = total / G_A;
      model(G_A, nw);
      checks++; if (ob_cyc_a.size() !== nw) begin errors++; $display("FAIL rnd_count got %0d want %0d", ob_cyc_a.size(), nw); end
      for (int i = 0; i < ob_cyc_a.size() && i < nw; i++) begin
        checks++; if (ob_cyc_a[i] !== G_A * (i + 1)) begin errors++; $display("FAIL rnd_time[%0d] got %0d want %0d", i, ob_cyc_a[i], G_A * (i + 1)); end
        checks++; if (ob_spd_a[i] !== exp_spd[i]) begin errors++; $display("FAIL rnd_speed[%0d] got %0d want %0d", i, ob_spd_a[i], exp_spd[i]); end
        checks++; if (ob_err_a[i] !== ((sp - exp_spd[i]) & 511)) begin errors++; $display("FAIL rnd_err[%0d] got %h want %h", i, ob_err_a[i], (sp - exp_spd[i]) & 511); end
      end
      checks++; if (flt_a !== exp_fault) begin errors++; $display("FAIL rnd_fault got %b want %b", flt_a, exp_fault); end
    end
  endtask

  task automatic test_glitch_fault();
    int sp, nw;
    sp = 200; setpoint = 8'(sp);
    seg_code = {}; seg_len = {};
    add_seg(HALL_S1, 40); add_seg(HALL_S2, 2); add_seg(HALL_S1, 40);
    add_seg(HALL_INVALID_HI, 10); add_seg(HALL_S1, 130);
    hall = HALL_S1;
    do_reset(2);
    play();
    nw = 222 / G_A;
    model(G_A, nw);
    checks++; if (ob_cyc_a.size() !== nw) begin errors++; $display("FAIL glitch_count got %0d want %0d", ob_cyc_a.size(), nw); end
    for (int i = 0; i < ob_cyc_a.size() && i < nw; i++) begin
      checks++; if (ob_spd_a[i] !== exp_spd[i]) begin errors++; $display("FAIL glitch_speed[%0d] got %0d want %0d", i, ob_spd_a[i], exp_spd[i]); end
      checks++; if (ob_err_a[i] !== ((sp - exp_spd[i]) & 511)) begin errors++; $display("FAIL glitch_err[%0d] got %h want %h", i, ob_err_a[i], (sp - exp_spd[i]) & 511); end
    end
    checks++; if (flt_a !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b want 1", flt_a); end
    do_reset(1);
    checks++; if (flt_a !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", flt_a); end
  endtask

  task automatic test_midreset();
    int sp, nw;
    sp = 10; setpoint = 8'(sp);
    seg_code = {}; seg_len = {};
    add_seg(HALL_S1, 10); add_seg(HALL_S2, 10); add_seg(HALL_S3, 10); add_seg(HALL_S4, 21);
    hall = HALL_S1;
    do_reset(2);
    play();
    checks++; if (ob_cyc_a.size() !== 0) begin errors++; $display("FAIL mid_early_pulse got %0d want 0", ob_cyc_a.size()); end
    do_reset(1);
    seg_code = {}; seg_len = {};
    for (int i = 0; i < 21; i++) add_seg(rot[(i + 4) % 6], 10);
    play();
    nw = 210 / G_A;
    model(G_A, nw);
    checks++; if (ob_cyc_a.size() !== nw) begin errors++; $display("FAIL mid_count got %0d want %0d", ob_cyc_a.size(), nw); end
    for (int i = 0; i < ob_cyc_a.size() && i < nw; i++) begin
      checks++; if (ob_cyc_a[i] !== G_A * (i + 1)) begin errors++; $display("FAIL mid_time[%0d] got %0d want %0d", i, ob_cyc_a[i], G_A * (i + 1)); end
      checks++; if (ob_spd_a[i] !== exp_spd[i]) begin errors++; $display("FAIL mid_speed[%0d] got %0d want %0d", i, ob_spd_a[i], exp_spd[i]); end
      checks++; if (ob_err_a[i] !== ((sp - exp_spd[i]) & 511)) begin errors++; $display("FAIL mid_err[%0d] got %h want %h", i, ob_err_a[i], (sp - exp_spd[i]) & 511); end
    end
  endtask

  task automatic test_saturation();
    int sp, nw, want0;
    sp = 0; setpoint = 8'(sp);
    seg_code = {}; seg_len = {};
    for (int i = 0; i < 669; i++) add_seg(rot[i % 6], 6);
    hall = 3'(rot[0]);
    do_reset(2);
    play();
    nw = (669 * 6) / G_B;
    model(G_B, nw);
`ifdef SPEED_AVG_EN
    want0 = 128;
`else
    want0 = 255;
`endif
    checks++; if (ob_cyc_b.size() !== nw) begin errors++; $display("FAIL sat_count got %0d want %0d", ob_cyc_b.size(), nw); end
    for (int i = 0; i < ob_cyc_b.size() && i < nw; i++) begin
      checks++; if (ob_cyc_b[i] !== G_B * (i + 1)) begin errors++; $display("FAIL sat_time[%0d] got %0d want %0d", i, ob_cyc_b[i], G_B * (i + 1)); end
      checks++; if (ob_spd_b[i] !== exp_spd[i]) begin errors++; $display("FAIL sat_speed[%0d] got %0d want %0d", i, ob_spd_b[i], exp_spd[i]); end
      checks++; if (ob_err_b[i] !== ((sp - exp_spd[i]) & 511)) begin errors++; $display("FAIL sat_err[%0d] got %h want %h", i, ob_err_b[i], (sp - exp_spd[i]) & 511); end
    end
    if (ob_cyc_b.size() > 1) begin
      checks++; if (ob_spd_b[0] !== want0) begin errors++; $display("FAIL sat_speed_w0 got %0d want %0d", ob_spd_b[0], want0); end
      checks++; if (ob_spd_b[1] !== 255) begin errors++; $display("FAIL sat_speed_w1 got %0d want 255", ob_spd_b[1]); end
      checks++; if (ob_err_b[1] !== 'h101) begin errors++; $display("FAIL sat_err_w1 got %h want 101", ob_err_b[1]); end
    end
  endtask

  initial begin
    rot[0] = HALL_S1; rot[1] = HALL_S2; rot[2] = HALL_S3;
    rot[3] = HALL_S4; rot[4] = HALL_S5; rot[5] = HALL_S6;
    test_reset();
    test_idle();
    test_rotate();
    test_random();
    test_glitch_fault();
    test_midreset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
